// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU. Ops wait here until both
// operands resolve, either at dispatch or by CDB snoop. One ready op issues per cycle.
module alu_rs #(
  parameter int RS_SZ      = 16,
  parameter int ROB_SZ_LOG = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clr_in,
  input  logic                in_flg,
  input  logic [ROB_SZ_LOG:0] in_rd,
  input  logic [31:0]         in_Vj,
  input  logic [31:0]         in_Vk,
  input  logic [ROB_SZ_LOG:0] in_Qj,
  input  logic [ROB_SZ_LOG:0] in_Qk,
  input  logic                in_j_rdy,
  input  logic                in_k_rdy,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_pc,
  input  logic [3:0]          in_opcode,
  input  logic [3:0]          in_optype,
  input  logic                alu_cdb_flg,
  input  logic [ROB_SZ_LOG:0] alu_cdb_rd,
  input  logic [31:0]         alu_cdb_res,
  input  logic                lsb_cdb_flg,
  input  logic [ROB_SZ_LOG:0] lsb_cdb_rd,
  input  logic [31:0]         lsb_cdb_res,
  output logic                full_out,
  output logic                run_flg,
  output logic [ROB_SZ_LOG:0] rd_to,
  output logic [31:0]         Vj,
  output logic [31:0]         Vk,
  output logic [31:0]         imm,
  output logic [31:0]         pc,
  output logic [3:0]          opcode,
  output logic [3:0]          optype
);

  localparam int TW = ROB_SZ_LOG + 1;
  localparam int IW = $clog2(RS_SZ);

  // Returns {hit, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] cdb_pick(
    input logic [TW-1:0] q,
    input logic          af,
    input logic [TW-1:0] ar,
    input logic [31:0]   av,
    input logic          lf,
    input logic [TW-1:0] lr,
    input logic [31:0]   lv
  );
    if (af && ar == q) return {1'b1, av};
    if (lf && lr == q) return {1'b1, lv};
    return {1'b0, 32'h0};
  endfunction

  logic [RS_SZ-1:0] ready_vec;
  logic [RS_SZ-1:0] busy_vec;
  logic [RS_SZ-1:0] busy_next;
  logic [TW-1:0]    rd_arr     [RS_SZ];
  logic [31:0]      vj_arr     [RS_SZ];
  logic [31:0]      vk_arr     [RS_SZ];
  logic [31:0]      imm_arr    [RS_SZ];
  logic [31:0]      pc_arr     [RS_SZ];
  logic [3:0]       opcode_arr [RS_SZ];
  logic [3:0]       optype_arr [RS_SZ];

  logic          issue_found;
  logic [IW-1:0] issue_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          disp_en;
  logic [32:0]   disp_j;
  logic [32:0]   disp_k;

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = RS_SZ - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        issue_found = 1'b1;
        issue_idx   = IW'(i);
      end
      if (!busy_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // A dispatch with no free slot is silently dropped.
  assign disp_en = in_flg && free_found;
  assign disp_j  = in_j_rdy ? {1'b1, in_Vj} :
                   cdb_pick(in_Qj, alu_cdb_flg, alu_cdb_rd, alu_cdb_res,
                            lsb_cdb_flg, lsb_cdb_rd, lsb_cdb_res);
  assign disp_k  = in_k_rdy ? {1'b1, in_Vk} :
                   cdb_pick(in_Qk, alu_cdb_flg, alu_cdb_rd, alu_cdb_res,
                            lsb_cdb_flg, lsb_cdb_rd, lsb_cdb_res);

  generate
    for (genvar gi = 0; gi < RS_SZ; gi++) begin : g_entry
      logic          busy_reg;
      logic          j_rdy_reg;
      logic          k_rdy_reg;
      logic [31:0]   vj_reg;
      logic [31:0]   vk_reg;
      logic [31:0]   imm_reg;
      logic [31:0]   pc_reg;
      logic [TW-1:0] qj_reg;
      logic [TW-1:0] qk_reg;
      logic [TW-1:0] rd_reg;
      logic [3:0]    opcode_reg;
      logic [3:0]    optype_reg;
      logic          disp_here;
      logic          issue_here;
      logic [32:0]   wake_j;
      logic [32:0]   wake_k;

      assign disp_here  = disp_en && (free_idx == IW'(gi));
      assign issue_here = issue_found && (issue_idx == IW'(gi));
      assign wake_j = cdb_pick(qj_reg, alu_cdb_flg, alu_cdb_rd, alu_cdb_res,
                               lsb_cdb_flg, lsb_cdb_rd, lsb_cdb_res);
      assign wake_k = cdb_pick(qk_reg, alu_cdb_flg, alu_cdb_rd, alu_cdb_res,
                               lsb_cdb_flg, lsb_cdb_rd, lsb_cdb_res);

      assign ready_vec[gi]  = busy_reg & j_rdy_reg & k_rdy_reg;
      assign busy_vec[gi]   = busy_reg;
      assign busy_next[gi]  = disp_here | (busy_reg & ~issue_here);
      assign rd_arr[gi]     = rd_reg;
      assign vj_arr[gi]     = vj_reg;
      assign vk_arr[gi]     = vk_reg;
      assign imm_arr[gi]    = imm_reg;
      assign pc_arr[gi]     = pc_reg;
      assign opcode_arr[gi] = opcode_reg;
      assign optype_arr[gi] = optype_reg;

      // Only busy needs a reset; payload fields are ignored while the slot is free.
      always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
          busy_reg <= 1'b0;
        end else if (rdy_in) begin
          busy_reg <= busy_next[gi];
          if (disp_here) begin
            j_rdy_reg  <= disp_j[32];
            vj_reg     <= disp_j[31:0];
            k_rdy_reg  <= disp_k[32];
            vk_reg     <= disp_k[31:0];
            qj_reg     <= in_Qj;
            qk_reg     <= in_Qk;
            rd_reg     <= in_rd;
            imm_reg    <= in_imm;
            pc_reg     <= in_pc;
            opcode_reg <= in_opcode;
            optype_reg <= in_optype;
          end else if (busy_reg) begin
            if (!j_rdy_reg && wake_j[32]) begin
              j_rdy_reg <= 1'b1;
              vj_reg    <= wake_j[31:0];
            end
            if (!k_rdy_reg && wake_k[32]) begin
              k_rdy_reg <= 1'b1;
              vk_reg    <= wake_k[31:0];
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_flg  <= 1'b0;
      full_out <= 1'b0;
      rd_to    <= '0;
      Vj       <= '0;
      Vk       <= '0;
      imm      <= '0;
      pc       <= '0;
      opcode   <= '0;
      optype   <= '0;
    end else if (clr_in) begin
      run_flg  <= 1'b0;
      full_out <= 1'b0;
    end else if (!rdy_in) begin
      run_flg <= 1'b0;
    end else begin
      run_flg  <= issue_found;
      full_out <= &busy_next;
      if (issue_found) begin
        rd_to  <= rd_arr[issue_idx];
        Vj     <= vj_arr[issue_idx];
        Vk     <= vk_arr[issue_idx];
        imm    <= imm_arr[issue_idx];
        pc     <= pc_arr[issue_idx];
        opcode <= opcode_arr[issue_idx];
        optype <= optype_arr[issue_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed sequences, a table of dispatch/CDB capture vectors,
// and a randomized run compared cycle by cycle against a behavioural model.
module tb_alu_rs;

  localparam int N = 16;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, in_flg;
  logic [4:0]  in_rd, in_Qj, in_Qk;
  logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
  logic        in_j_rdy, in_k_rdy;
  logic [3:0]  in_opcode, in_optype;
  logic        alu_cdb_flg, lsb_cdb_flg;
  logic [4:0]  alu_cdb_rd, lsb_cdb_rd;
  logic [31:0] alu_cdb_res, lsb_cdb_res;
  logic        full_out, run_flg;
  logic [4:0]  rd_to;
  logic [31:0] Vj, Vk, imm, pc;
  logic [3:0]  opcode, optype;

  int tests = 0;
  int fails = 0;

  alu_rs #(.RS_SZ(N), .ROB_SZ_LOG(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .in_flg(in_flg), .in_rd(in_rd), .in_Vj(in_Vj), .in_Vk(in_Vk),
    .in_Qj(in_Qj), .in_Qk(in_Qk), .in_j_rdy(in_j_rdy), .in_k_rdy(in_k_rdy),
    .in_imm(in_imm), .in_pc(in_pc), .in_opcode(in_opcode), .in_optype(in_optype),
    .alu_cdb_flg(alu_cdb_flg), .alu_cdb_rd(alu_cdb_rd), .alu_cdb_res(alu_cdb_res),
    .lsb_cdb_flg(lsb_cdb_flg), .lsb_cdb_rd(lsb_cdb_rd), .lsb_cdb_res(lsb_cdb_res),
    .full_out(full_out), .run_flg(run_flg), .rd_to(rd_to), .Vj(Vj), .Vk(Vk),
    .imm(imm), .pc(pc), .opcode(opcode), .optype(optype)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a set of waiting ops plus the last issued bundle.
  typedef struct packed {
    logic        busy, jr, kr;
    logic [31:0] vj, vk, imm, pc;
    logic [4:0]  qj, qk, rd;
    logic [3:0]  opc, opt;
  } ent_t;

  ent_t        m_ent [N];
  logic        m_run = 1'b0, m_full = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_vj = '0, m_vk = '0, m_imm = '0, m_pc = '0;
  logic [3:0]  m_opc = '0, m_opt = '0;

  function automatic logic [32:0] m_snoop(input logic [4:0] q);
    if (alu_cdb_flg && alu_cdb_rd == q) return {1'b1, alu_cdb_res};
    if (lsb_cdb_flg && lsb_cdb_rd == q) return {1'b1, lsb_cdb_res};
    return 33'h0;
  endfunction

  task automatic model_edge();
    int iss, fr;
    logic [32:0] w;
    if (rst_in) begin
      for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
      m_run = 0; m_full = 0; m_rd = '0; m_vj = '0; m_vk = '0;
      m_imm = '0; m_pc = '0; m_opc = '0; m_opt = '0;
      return;
    end
    if (clr_in) begin
      for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
      m_run = 0; m_full = 0;
      return;
    end
    if (!rdy_in) begin
      m_run = 0;
      return;
    end
    iss = -1; fr = -1;
    for (int i = 0; i < N; i++) begin
      if (iss < 0 && m_ent[i].busy && m_ent[i].jr && m_ent[i].kr) iss = i;
      if (fr < 0 && !m_ent[i].busy) fr = i;
    end
    m_run = (iss >= 0);
    if (iss >= 0) begin
      m_rd = m_ent[iss].rd; m_vj = m_ent[iss].vj; m_vk = m_ent[iss].vk;
      m_imm = m_ent[iss].imm; m_pc = m_ent[iss].pc;
      m_opc = m_ent[iss].opc; m_opt = m_ent[iss].opt;
      m_ent[iss].busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_ent[i].busy && !m_ent[i].jr) begin
        w = m_snoop(m_ent[i].qj);
        if (w[32]) begin m_ent[i].jr = 1'b1; m_ent[i].vj = w[31:0]; end
      end
      if (m_ent[i].busy && !m_ent[i].kr) begin
        w = m_snoop(m_ent[i].qk);
        if (w[32]) begin m_ent[i].kr = 1'b1; m_ent[i].vk = w[31:0]; end
      end
    end
    if (in_flg && fr >= 0) begin
      m_ent[fr].busy = 1'b1;
      w = in_j_rdy ? {1'b1, in_Vj} : m_snoop(in_Qj);
      m_ent[fr].jr = w[32]; m_ent[fr].vj = w[31:0];
      w = in_k_rdy ? {1'b1, in_Vk} : m_snoop(in_Qk);
      m_ent[fr].kr = w[32]; m_ent[fr].vk = w[31:0];
      m_ent[fr].qj = in_Qj; m_ent[fr].qk = in_Qk; m_ent[fr].rd = in_rd;
      m_ent[fr].imm = in_imm; m_ent[fr].pc = in_pc;
      m_ent[fr].opc = in_opcode; m_ent[fr].opt = in_optype;
    end
    m_full = 1'b1;
    for (int i = 0; i < N; i++) if (!m_ent[i].busy) m_full = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input int cyc);
    logic [142:0] a, e;
    a = {run_flg, full_out, rd_to, Vj, Vk, imm, pc, opcode, optype};
    e = {m_run, m_full, m_rd, m_vj, m_vk, m_imm, m_pc, m_opc, m_opt};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL model_cmp cycle %0d: got %h expected %h", cyc, a, e);
    end
  endtask

  task automatic idle();
    in_flg = 0; alu_cdb_flg = 0; lsb_cdb_flg = 0; clr_in = 0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] vj, input logic jr,
                      input logic [4:0] qj, input logic [31:0] vk, input logic kr,
                      input logic [4:0] qk);
    in_flg = 1; in_rd = rd; in_Vj = vj; in_j_rdy = jr; in_Qj = qj;
    in_Vk = vk; in_k_rdy = kr; in_Qk = qk;
    in_imm = 32'h100 + 32'(rd); in_pc = 32'h1000 + 32'(rd) * 4;
    in_opcode = rd[3:0]; in_optype = 4'h1;
  endtask

  // Dispatching into a full station is a dispatcher protocol error.
  always @(negedge clk_in) begin
    if (!rst_in && !clr_in && rdy_in && in_flg && full_out) begin
      fails++;
      $display("FAIL dispatch_while_full: full_out=%0b expected 0 with in_flg=1", full_out);
    end
  end

  typedef struct packed {
    logic [4:0]  rd, qj, qk;
    logic        jr, kr;
    logic [31:0] vj, vk;
    logic        af;
    logic [4:0]  ar;
    logic [31:0] av;
    logic        lf;
    logic [4:0]  lr;
    logic [31:0] lv;
    logic        exp_run;
    logic [31:0] exp_vj, exp_vk;
  } vec_t;

  vec_t vecs [9];

  initial begin
    rst_in = 1; rdy_in = 1; clr_in = 0; in_flg = 0;
    in_rd = '0; in_Qj = '0; in_Qk = '0; in_Vj = '0; in_Vk = '0;
    in_j_rdy = 0; in_k_rdy = 0; in_imm = '0; in_pc = '0; in_opcode = '0; in_optype = '0;
    alu_cdb_flg = 0; alu_cdb_rd = '0; alu_cdb_res = '0;
    lsb_cdb_flg = 0; lsb_cdb_rd = '0; lsb_cdb_res = '0;

    // 1: reset values, then a fully ready op
    tick(); tick(); rst_in = 0;
    chk("rst_run", 32'(run_flg), 0);
    chk("rst_full", 32'(full_out), 0);
    chk("rst_rd_to", 32'(rd_to), 0);
    chk("rst_vj", Vj, 0);
    disp(5'd3, 32'd5, 1, 5'd0, 32'd7, 1, 5'd0);
    tick(); idle();
    chk("t1_run_early", 32'(run_flg), 0);
    tick();
    chk("t1_run", 32'(run_flg), 1);
    chk("t1_rd_to", 32'(rd_to), 3);
    chk("t1_vj", Vj, 5);
    chk("t1_vk", Vk, 7);
    chk("t1_full", 32'(full_out), 0);
    tick();
    chk("t1_strobe", 32'(run_flg), 0);
    $display("[TB] test1 ready op rd=3 issued Vj=%0d Vk=%0d", 5, 7);

    // 2: operand resolved by ALU broadcast two cycles later
    disp(5'd4, 32'hBAD, 0, 5'd2, 32'd1, 1, 5'd0);
    tick(); idle();
    tick(); chk("t2_wait0", 32'(run_flg), 0);
    tick(); chk("t2_wait1", 32'(run_flg), 0);
    alu_cdb_flg = 1; alu_cdb_rd = 5'd2; alu_cdb_res = 32'd10;
    tick(); idle();
    chk("t2_bcast_edge", 32'(run_flg), 0);
    tick();
    chk("t2_run", 32'(run_flg), 1);
    chk("t2_rd_to", 32'(rd_to), 4);
    chk("t2_vj", Vj, 10);
    chk("t2_vk", Vk, 1);
    $display("[TB] test2 woken op rd=4 issued");

    // 3: same-cycle capture from LSB bus at dispatch
    disp(5'd5, 32'd3, 1, 5'd0, 32'hBAD, 0, 5'd6);
    lsb_cdb_flg = 1; lsb_cdb_rd = 5'd6; lsb_cdb_res = 32'hDEADBEEF;
    tick(); idle();
    chk("t3_run_early", 32'(run_flg), 0);
    tick();
    chk("t3_run", 32'(run_flg), 1);
    chk("t3_rd_to", 32'(rd_to), 5);
    chk("t3_vk", Vk, 32'hDEADBEEF);
    $display("[TB] test3 dispatch capture rd=5 issued");

    // 4: fill all entries, wake only entry 9
    for (int i = 0; i < N; i++) begin
      disp(5'(i), 32'hBAD, 0, 5'(16 + i), 32'(i), 1, 5'd0);
      tick();
      if (i == N - 2) chk("t4_not_full", 32'(full_out), 0);
    end
    idle();
    chk("t4_full", 32'(full_out), 1);
    chk("t4_no_issue", 32'(run_flg), 0);
    alu_cdb_flg = 1; alu_cdb_rd = 5'd25; alu_cdb_res = 32'd99;
    tick(); idle();
    chk("t4_bcast_run", 32'(run_flg), 0);
    tick();
    chk("t4_run", 32'(run_flg), 1);
    chk("t4_rd_to", 32'(rd_to), 9);
    chk("t4_vj", Vj, 99);
    chk("t4_full_after", 32'(full_out), 0);
    disp(5'd30, 32'd1, 1, 5'd0, 32'd2, 1, 5'd0);
    tick(); idle();
    chk("t4_refull", 32'(full_out), 1);
    tick();
    chk("t4_reuse_run", 32'(run_flg), 1);
    chk("t4_reuse_rd", 32'(rd_to), 30);
    clr_in = 1; tick(); idle();
    $display("[TB] test4 full station, entry 9 woken and reused");

    // 5: three ops woken together issue in order; flush cancels the third
    for (int i = 0; i < 3; i++) begin
      disp(5'(10 + i), 32'hBAD, 0, 5'd7, 32'(i), 1, 5'd0);
      tick();
    end
    idle();
    alu_cdb_flg = 1; alu_cdb_rd = 5'd7; alu_cdb_res = 32'h70;
    tick(); idle();
    chk("t5_bcast_run", 32'(run_flg), 0);
    tick();
    chk("t5_run0", 32'(run_flg), 1);
    chk("t5_rd0", 32'(rd_to), 10);
    chk("t5_vj0", Vj, 32'h70);
    tick();
    chk("t5_run1", 32'(run_flg), 1);
    chk("t5_rd1", 32'(rd_to), 11);
    clr_in = 1; tick(); idle();
    chk("t5_clr_run", 32'(run_flg), 0);
    chk("t5_clr_full", 32'(full_out), 0);
    tick();
    chk("t5_no_entry2", 32'(run_flg), 0);
    $display("[TB] test5 in-order issue then flush");

    // 6: pause, then reset mid-stream
    disp(5'd13, 32'h13, 1, 5'd0, 32'h31, 1, 5'd0);
    tick(); idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_paused", 32'(run_flg), 0);
    end
    rdy_in = 1;
    tick();
    chk("t6_release_run", 32'(run_flg), 1);
    chk("t6_release_rd", 32'(rd_to), 13);
    disp(5'd14, 32'h14, 1, 5'd0, 32'h41, 1, 5'd0);
    tick(); idle();
    rst_in = 1; tick(); rst_in = 0;
    chk("t6_rst_run", 32'(run_flg), 0);
    chk("t6_rst_rd", 32'(rd_to), 0);
    chk("t6_rst_vj", Vj, 0);
    chk("t6_rst_vk", Vk, 0);
    chk("t6_rst_imm", imm, 0);
    chk("t6_rst_pc", pc, 0);
    chk("t6_rst_opc", {28'h0, opcode}, 0);
    chk("t6_rst_opt", {28'h0, optype}, 0);
    chk("t6_rst_full", 32'(full_out), 0);
    tick();
    chk("t6_rst_gone", 32'(run_flg), 0);
    $display("[TB] test6 pause and reset");

    // Capture-at-dispatch table: {rd,qj,qk,jr,kr,vj,vk,af,ar,av,lf,lr,lv,exp_run,exp_vj,exp_vk}
    vecs[0] = '{5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'd11, 32'd22, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 1'b1, 32'd11, 32'd22};
    vecs[1] = '{5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 32'hBAD, 32'd5, 1'b1, 5'd3, 32'd100,
                1'b0, 5'd0, 32'd0, 1'b1, 32'd100, 32'd5};
    vecs[2] = '{5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 32'd7, 32'hBAD, 1'b0, 5'd0, 32'd0,
                1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 32'd7, 32'hCAFEF00D};
    vecs[3] = '{5'd4, 5'd1, 5'd2, 1'b0, 1'b0, 32'hBAD, 32'hBAD, 1'b1, 5'd1, 32'h111,
                1'b1, 5'd2, 32'h222, 1'b1, 32'h111, 32'h222};
    vecs[4] = '{5'd5, 5'd6, 5'd0, 1'b0, 1'b1, 32'hBAD, 32'd3, 1'b1, 5'd6, 32'hA,
                1'b1, 5'd6, 32'hB, 1'b1, 32'hA, 32'd3};
    vecs[5] = '{5'd6, 5'h12, 5'd0, 1'b0, 1'b1, 32'hBAD, 32'd3, 1'b1, 5'h02, 32'h55,
                1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    vecs[6] = '{5'd7, 5'd4, 5'd0, 1'b1, 1'b1, 32'h77, 32'd8, 1'b1, 5'd4, 32'h99,
                1'b0, 5'd0, 32'd0, 1'b1, 32'h77, 32'd8};
    vecs[7] = '{5'd8, 5'd0, 5'd3, 1'b1, 1'b0, 32'd1, 32'hBAD, 1'b0, 5'd3, 32'h44,
                1'b0, 5'd3, 32'h45, 1'b0, 32'd0, 32'd0};
    vecs[8] = '{5'd9, 5'd7, 5'd0, 1'b0, 1'b1, 32'hBAD, 32'd6, 1'b1, 5'd8, 32'h88,
                1'b1, 5'd7, 32'h77, 1'b1, 32'h77, 32'd6};
    for (int v = 0; v < 9; v++) begin
      clr_in = 1; tick(); idle();
      disp(vecs[v].rd, vecs[v].vj, vecs[v].jr, vecs[v].qj, vecs[v].vk, vecs[v].kr, vecs[v].qk);
      alu_cdb_flg = vecs[v].af; alu_cdb_rd = vecs[v].ar; alu_cdb_res = vecs[v].av;
      lsb_cdb_flg = vecs[v].lf; lsb_cdb_rd = vecs[v].lr; lsb_cdb_res = vecs[v].lv;
      tick(); idle(); tick();
      chk($sformatf("vec%0d_run", v), 32'(run_flg), 32'(vecs[v].exp_run));
      if (vecs[v].exp_run) begin
        chk($sformatf("vec%0d_rd", v), 32'(rd_to), 32'(vecs[v].rd));
        chk($sformatf("vec%0d_vj", v), Vj, vecs[v].exp_vj);
        chk($sformatf("vec%0d_vk", v), Vk, vecs[v].exp_vk);
      end
      $display("[TB] vec %0d rd=%0d run=%0b Vj=%h Vk=%h", v, vecs[v].rd, run_flg, Vj, Vk);
    end

    // Randomized traffic against the model
    rst_in = 1; tick(); rst_in = 0;
    for (int c = 0; c < 600; c++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      clr_in      = ($urandom_range(0, 39) == 0);
      rst_in      = ($urandom_range(0, 199) == 0);
      in_flg      = rdy_in && !m_full && 1'($urandom_range(0, 1));
      in_rd       = 5'($urandom_range(0, 31));
      in_Qj       = 5'($urandom_range(0, 7));
      in_Qk       = 5'($urandom_range(0, 7));
      in_j_rdy    = 1'($urandom_range(0, 1));
      in_k_rdy    = 1'($urandom_range(0, 1));
      in_Vj       = $urandom();
      in_Vk       = $urandom();
      in_imm      = $urandom();
      in_pc       = $urandom();
      in_opcode   = 4'($urandom_range(0, 15));
      in_optype   = 4'($urandom_range(0, 15));
      alu_cdb_flg = 1'($urandom_range(0, 1));
      alu_cdb_rd  = 5'($urandom_range(0, 7));
      alu_cdb_res = $urandom();
      lsb_cdb_flg = 1'($urandom_range(0, 1));
      lsb_cdb_rd  = 5'($urandom_range(0, 7));
      lsb_cdb_res = $urandom();
      tick();
      chk_model(c);
      if (run_flg) $display("[TB] rnd cycle %0d issue rd=%0d Vj=%h Vk=%h", c, rd_to, Vj, Vk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
